// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, ms debounce FSM, clean level and press/release/long pulses
//   clk_24M     in   system clock, rising edge
//   reset0      in   synchronous active-low reset
//   key_in      in   raw asynchronous buttons [N_KEYS]
//   key_level   out  debounced level, 1 = pressed
//   key_press   out  1-cycle pulse on accepted press
//   key_release out  1-cycle pulse on accepted release
//   key_long    out  1-cycle pulse once per press when hold reaches LONG_MS
module key_debounce #(
   parameter int N_KEYS         = 3,
   parameter int CLK_HZ         = 24_000_000,
   parameter int DEBOUNCE_MS    = 20,
   parameter int LONG_MS        = 1000,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic              clk_24M,
   input  logic              reset0,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);
   localparam int TICK_DIV = CLK_HZ / 1000;
   localparam int TW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int MAX_MS   = DEBOUNCE_MS > LONG_MS ? DEBOUNCE_MS : LONG_MS;
   localparam int CW       = $clog2(MAX_MS + 1);
   localparam logic [N_KEYS-1:0] INACTIVE = {N_KEYS{KEY_ACTIVE_LOW}};
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   logic [TW-1:0]     tick_cnt;
   logic              ms_tick;
   logic [N_KEYS-1:0] sync1, sync2, raw;
   assign ms_tick = tick_cnt == TW'(TICK_DIV - 1);
   assign raw     = sync2 ^ INACTIVE;
   always_ff @(posedge clk_24M) begin
      if (!reset0) begin
         tick_cnt <= '0;
         sync1    <= INACTIVE;
         sync2    <= INACTIVE;
      end else begin
         tick_cnt <= ms_tick ? '0 : tick_cnt + TW'(1);
         sync1    <= key_in;
         sync2    <= sync1;
      end
   end
   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      state_t        state, state_nxt;
      logic [CW-1:0] cnt, cnt_nxt, hold, hold_nxt;
      logic          long_hit;
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         hold_nxt  = hold;
         long_hit  = 1'b0;
         case (state)
            IDLE: begin
               if (raw[k]) begin
                  state_nxt = PRESS_WAIT;
                  cnt_nxt   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!raw[k]) state_nxt = IDLE;
               else if (ms_tick) begin
                  cnt_nxt = cnt + CW'(1);
                  if (cnt == CW'(DEBOUNCE_MS - 1)) begin
                     state_nxt = PRESSED;
                     hold_nxt  = '0;
                  end
               end
            end
            PRESSED: begin
               // hold saturates at LONG_MS, so a bounce back into PRESSED cannot fire key_long again
               if (ms_tick && hold != CW'(LONG_MS)) begin
                  hold_nxt = hold + CW'(1);
                  long_hit = (LONG_MS > 0) && (hold == CW'(LONG_MS - 1));
               end
               if (!raw[k]) begin
                  state_nxt = RELEASE_WAIT;
                  cnt_nxt   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (raw[k]) state_nxt = PRESSED;
               else if (ms_tick) begin
                  cnt_nxt = cnt + CW'(1);
                  if (cnt == CW'(DEBOUNCE_MS - 1)) state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      always_ff @(posedge clk_24M) begin
         if (!reset0) begin
            state          <= IDLE;
            cnt            <= '0;
            hold           <= '0;
            key_level[k]   <= 1'b0;
            key_press[k]   <= 1'b0;
            key_release[k] <= 1'b0;
            key_long[k]    <= 1'b0;
         end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            hold           <= hold_nxt;
            key_level[k]   <= state_nxt == PRESSED || state_nxt == RELEASE_WAIT;
            key_press[k]   <= state == PRESS_WAIT && state_nxt == PRESSED;
            key_release[k] <= state == RELEASE_WAIT && state_nxt == IDLE;
            key_long[k]    <= long_hit;
         end
      end
   end
endmodule
